stream_rr_arbiter: RTL and testbench

Round-robin burst arbiter that shares one 512-bit AXI-Stream processing lane (a `data_proc`-class operator behind a relay station) between up to four DMA input streams. Each grant lasts a fixed `BURST_LEN` beats, after which ownership rotates to the next requesting input. Output is a single registered stage with full-throughput ready/valid. It sits between the DMA-side stream links and the shared operator's `Input_1` port.

---
 rtl/stream_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter: NUM_IN AXI-Stream inputs share one output lane, BURST_LEN beats per grant.
// Latency: 1 cycle input-to-output through a single registered stage; one IDLE cycle per grant.
// Backpressure: granted In_TREADY = ~out_valid | Output_1_TREADY; a full, stalled output register holds.
// Optional: define STREAM_ARB_TID_EN to add Output_1_TID (source index of each output beat).
module stream_rr_arbiter #(
  parameter int PAYLOAD_BITS = 512,
  parameter int NUM_IN       = 4,
  parameter int BURST_LEN    = 16
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [NUM_IN*PAYLOAD_BITS-1:0] In_TDATA,
  input  logic [NUM_IN-1:0]              In_TVALID,
  output logic [NUM_IN-1:0]              In_TREADY,
  output logic [PAYLOAD_BITS-1:0]        Output_1_TDATA,
  output logic                           Output_1_TVALID,
  input  logic                           Output_1_TREADY,
`ifdef STREAM_ARB_TID_EN
  output logic [1:0]                     Output_1_TID,
`endif
  output logic [1:0]                     grant_idx,
  output logic                           busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [7:0]              beat_cnt;

  logic [3:0]              vld_pad;
  logic                    any_vld;
  logic                    out_free;
  logic                    accept;
  logic                    last_beat;
  logic [1:0]              pick;
  logic [1:0]              next_ptr;
  logic [2:0]              cand;
  logic                    found;
  logic [PAYLOAD_BITS-1:0] sel_dat;

  // Valids widened to four lanes so a 2-bit index is always in range.
  always_comb begin
    vld_pad               = '0;
    vld_pad[NUM_IN-1:0]   = In_TVALID;
    any_vld               = |In_TVALID;
  end

  // Output slot can take a beat when empty or being drained this cycle.
  always_comb begin
    out_free  = ~Output_1_TVALID | Output_1_TREADY;
    accept    = (state == GRANT) && out_free && vld_pad[grant_idx];
    last_beat = (beat_cnt == 8'(BURST_LEN - 1));
    next_ptr  = (grant_idx == 2'(NUM_IN - 1)) ? 2'd0 : grant_idx + 2'd1;
  end

  // Ready depends only on state and downstream ready, never on any input valid.
  always_comb begin
    In_TREADY = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      In_TREADY[i] = (state == GRANT) && (grant_idx == 2'(i)) && out_free;
    end
  end

  // First valid input scanning upward from rr_ptr, wrapping at NUM_IN.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NUM_IN)) begin
        cand = cand - 3'(NUM_IN);
      end
      if (!found && vld_pad[cand[1:0]]) begin
        pick  = cand[1:0];
        found = 1'b1;
      end
    end
  end

  // Payload of the granted input.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_dat = In_TDATA[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // Arbitration FSM: grant on IDLE->GRANT, rotate pointer after the last beat of a burst.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      grant_idx <= 2'd0;
      beat_cnt  <= 8'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            grant_idx <= pick;
            beat_cnt  <= 8'd0;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A stalled or silent owner keeps the grant; there is no timeout.
          if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      Output_1_TVALID <= 1'b0;
      Output_1_TDATA  <= '0;
    end else if (accept) begin
      Output_1_TVALID <= 1'b1;
      Output_1_TDATA  <= sel_dat;
    end else if (Output_1_TREADY) begin
      Output_1_TVALID <= 1'b0;
    end
  end

`ifdef STREAM_ARB_TID_EN
  // Source index travels with each beat and holds alongside the data.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      Output_1_TID <= 2'd0;
    end else if (accept) begin
      Output_1_TID <= grant_idx;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: one 4-input/4-beat instance and one 3-input/2-beat instance.
// Each check is an immediate assertion against hand-derived expectations.
// Sources advance their beat counter only on a ready&valid handshake.
module tb_stream_rr_arbiter;
  localparam int PB = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 4-input instance, BURST_LEN = 4
  logic [4*PB-1:0] d4;
  logic [3:0]      v4;
  logic [3:0]      r4;
  logic [PB-1:0]   od4;
  logic            ov4;
  logic            or4;
  logic [1:0]      g4;
  logic            b4;
  // 3-input instance, BURST_LEN = 2
  logic [3*PB-1:0] d3;
  logic [2:0]      v3;
  logic [2:0]      r3;
  logic [PB-1:0]   od3;
  logic            ov3;
  logic            or3;
  logic [1:0]      g3;
  logic            b3;
`ifdef STREAM_ARB_TID_EN
  logic [1:0]      tid4;
  logic [1:0]      tid3;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int c4[4];
  int c3[3];

  stream_rr_arbiter #(.PAYLOAD_BITS(PB), .NUM_IN(4), .BURST_LEN(4)) u4 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .In_TDATA(d4), .In_TVALID(v4), .In_TREADY(r4),
    .Output_1_TDATA(od4), .Output_1_TVALID(ov4), .Output_1_TREADY(or4),
`ifdef STREAM_ARB_TID_EN
    .Output_1_TID(tid4),
`endif
    .grant_idx(g4), .busy(b4)
  );

  stream_rr_arbiter #(.PAYLOAD_BITS(PB), .NUM_IN(3), .BURST_LEN(2)) u3 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .In_TDATA(d3), .In_TVALID(v3), .In_TREADY(r3),
    .Output_1_TDATA(od3), .Output_1_TVALID(ov3), .Output_1_TREADY(or3),
`ifdef STREAM_ARB_TID_EN
    .Output_1_TID(tid3),
`endif
    .grant_idx(g3), .busy(b3)
  );

  // Beat k of source src: source tag in the top byte, source/beat in the low bytes.
  function automatic logic [PB-1:0] mk(input int src, input int k);
    logic [PB-1:0] d;
    d            = '0;
    d[PB-1 -: 8] = 8'(src + 16);
    d[15:8]      = 8'(src);
    d[7:0]       = 8'(k);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) d4[i*PB +: PB] = mk(i, c4[i]);
    for (int i = 0; i < 3; i++) d3[i*PB +: PB] = mk(i, c3[i]);
  endtask

  // Advance one clock; sources whose handshake was up before the edge move to their next beat.
  task automatic tick();
    logic [3:0] f4;
    logic [2:0] f3;
    f4 = v4 & r4;
    f3 = v3 & r3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (f4[i]) c4[i]++;
    for (int i = 0; i < 3; i++) if (f3[i]) c3[i]++;
    drive();
  endtask

  task automatic exp4(input string tag, input logic ev, input logic [PB-1:0] ed, input logic eb,
                      input logic [1:0] eg, input logic [3:0] er, input logic [1:0] et);
    chk({tag, ".vld"}, PB'(ov4), PB'(ev));
    if (ev) begin
      chk({tag, ".dat"}, od4, ed);
`ifdef STREAM_ARB_TID_EN
      chk({tag, ".tid"}, PB'(tid4), PB'(et));
`endif
    end
    chk({tag, ".busy"}, PB'(b4), PB'(eb));
    chk({tag, ".grant"}, PB'(g4), PB'(eg));
    chk({tag, ".rdy"}, PB'(r4), PB'(er));
  endtask

  task automatic exp3(input string tag, input logic ev, input logic [PB-1:0] ed, input logic eb,
                      input logic [1:0] eg, input logic [2:0] er, input logic [1:0] et);
    chk({tag, ".vld"}, PB'(ov3), PB'(ev));
    if (ev) begin
      chk({tag, ".dat"}, od3, ed);
`ifdef STREAM_ARB_TID_EN
      chk({tag, ".tid"}, PB'(tid3), PB'(et));
`endif
    end
    chk({tag, ".busy"}, PB'(b3), PB'(eb));
    chk({tag, ".grant"}, PB'(g3), PB'(eg));
    chk({tag, ".rdy"}, PB'(r3), PB'(er));
  endtask

  initial begin
    int order[4];
    int base;
    int src;
    order = '{0, 1, 2, 0};
    v4  = '0;
    v3  = '0;
    or4 = 1'b1;
    or3 = 1'b1;
    for (int i = 0; i < 4; i++) c4[i] = 0;
    for (int i = 0; i < 3; i++) c3[i] = 0;
    drive();

    // Reset state
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.vld",   PB'(ov4), PB'(0));
    chk("rst.dat",   od4, '0);
    chk("rst.busy",  PB'(b4), PB'(0));
    chk("rst.grant", PB'(g4), PB'(0));
    chk("rst.rdy",   PB'(r4), PB'(0));

    // Single requester (input 1): 4 back-to-back beats, one IDLE cycle, re-grant
    rst_n = 1'b1;
    v4    = 4'b0010;
    tick(); exp4("t1c1", 0, '0,       1, 2'd1, 4'b0010, 2'd1);
    tick(); exp4("t1c2", 1, mk(1, 0), 1, 2'd1, 4'b0010, 2'd1);
    tick(); exp4("t1c3", 1, mk(1, 1), 1, 2'd1, 4'b0010, 2'd1);
    tick(); exp4("t1c4", 1, mk(1, 2), 1, 2'd1, 4'b0010, 2'd1);
    tick(); exp4("t1c5", 1, mk(1, 3), 0, 2'd1, 4'b0000, 2'd1);
    tick(); exp4("t1c6", 0, '0,       1, 2'd1, 4'b0010, 2'd1);
    tick(); exp4("t1c7", 1, mk(1, 4), 1, 2'd1, 4'b0010, 2'd1);
    tick(); exp4("t1c8", 1, mk(1, 5), 1, 2'd1, 4'b0010, 2'd1);

    // Asynchronous reset after beat 2 of the burst
    #3 rst_n = 1'b0;
    #1;
    chk("rst1.vld",   PB'(ov4), PB'(0));
    chk("rst1.rdy",   PB'(r4), PB'(0));
    chk("rst1.busy",  PB'(b4), PB'(0));
    chk("rst1.grant", PB'(g4), PB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Inputs 0 and 2 contend: 0 x4, bubble, 2 x4, bubble, 0 again
    v4 = 4'b0101;
    tick(); exp4("t2c1", 0, '0, 1, 2'd0, 4'b0001, 2'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp4($sformatf("t2s0b%0d", k), 1, mk(0, k), (k != 3), 2'd0, (k == 3) ? 4'b0000 : 4'b0001, 2'd0);
    end
    tick(); exp4("t2c6", 0, '0, 1, 2'd2, 4'b0100, 2'd2);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp4($sformatf("t2s2b%0d", k), 1, mk(2, k), (k != 3), 2'd2, (k == 3) ? 4'b0000 : 4'b0100, 2'd2);
    end
    tick(); exp4("t2c11", 0, '0,       1, 2'd0, 4'b0001, 2'd0);
    tick(); exp4("t4c0",  1, mk(0, 4), 1, 2'd0, 4'b0001, 2'd0);

    // Downstream stall for 5 cycles: register full, ready low, data/valid held
    or4 = 1'b0;
    #1;
    chk("t4.rdy_stall", PB'(r4), PB'(0));
    for (int s = 0; s < 5; s++) begin
      tick();
      exp4($sformatf("t4stall%0d", s), 1, mk(0, 4), 1, 2'd0, 4'b0000, 2'd0);
    end
    or4 = 1'b1;
    #1;
    chk("t4.rdy_resume", PB'(r4), PB'(4'b0001));
    tick(); exp4("t4c6", 1, mk(0, 5), 1, 2'd0, 4'b0001, 2'd0);
    tick(); exp4("t4c7", 1, mk(0, 6), 1, 2'd0, 4'b0001, 2'd0);
    tick(); exp4("t4c8", 1, mk(0, 7), 0, 2'd0, 4'b0000, 2'd0);
    chk("t4.src0_beats", PB'(c4[0]), PB'(8));
    chk("t4.src2_beats", PB'(c4[2]), PB'(4));

    // Reset with rr_ptr at 1: restart must scan from 0 again
    #3 rst_n = 1'b0;
    #1;
    chk("rst2.vld", PB'(ov4), PB'(0));
    chk("rst2.rdy", PB'(r4), PB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v4    = 4'b0011;
    tick(); exp4("t5c1", 0, '0,       1, 2'd0, 4'b0001, 2'd0);
    tick(); exp4("t5c2", 1, mk(0, 8), 1, 2'd0, 4'b0001, 2'd0);

    // Owner drops valid mid-burst: grant stays, input 1 keeps waiting
    v4 = 4'b0010;
    #1;
    chk("t5.rdy_hold", PB'(r4), PB'(4'b0001));
    tick(); exp4("t5c3", 0, '0, 1, 2'd0, 4'b0001, 2'd0);
    tick(); exp4("t5c4", 0, '0, 1, 2'd0, 4'b0001, 2'd0);
    v4 = 4'b0011;
    tick(); exp4("t5c5", 1, mk(0, 9), 1, 2'd0, 4'b0001, 2'd0);

    // Three inputs, all valid: grants 0,1,2,0 with wrap from 2 to 0
    #3 rst_n = 1'b0;
    #1;
    chk("rst3.vld3", PB'(ov3), PB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v4    = 4'b0000;
    v3    = 3'b111;
    for (int b = 0; b < 4; b++) begin
      src  = order[b];
      base = (b == 3) ? 2 : 0;
      tick();
      exp3($sformatf("t3g%0d", b), 0, '0, 1, 2'(src), 3'(1 << src), 2'(src));
      for (int k = 0; k < 2; k++) begin
        tick();
        exp3($sformatf("t3g%0db%0d", b, k), 1, mk(src, base + k), (k == 0), 2'(src),
             (k == 0) ? 3'(1 << src) : 3'b000, 2'(src));
      end
    end
    chk("t3.src0_beats", PB'(c3[0]), PB'(4));
    chk("t3.src1_beats", PB'(c3[1]), PB'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard bound so a stuck run still terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
